// File: rtl/tri_vertex_packer.sv
// Rasterizer transmit front end: gathers VERTS serial vertex beats into one
// polygon and hands it to the bbox stage over a valid/halt interface.
module tri_vertex_packer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vert_valid_i,
  output logic                          vert_ready_o,
  input  logic                          vert_last_i,
  input  logic [AXIS*SIGFIG-1:0]        vert_pos_i,
  input  logic [COLORS*SIGFIG-1:0]      vert_color_i,
  output logic                          tri_valid_o,
  input  logic                          tri_halt_i,
  output logic [VERTS*AXIS*SIGFIG-1:0]  tri_o,
  output logic [COLORS*SIGFIG-1:0]      color_o,
  output logic                          err_o,
  output logic [CNT_W-1:0]              tri_count_o
);

  localparam int VW     = AXIS * SIGFIG;
  localparam int TRI_W  = VERTS * VW;
  localparam int CW     = COLORS * SIGFIG;
  localparam int BEAT_W = (VERTS > 1) ? $clog2(VERTS) : 1;

  // Fixed-point fraction width is only carried along, so it must fit the word.
  if (RADIX >= SIGFIG) begin : g_bad_radix
    $error("RADIX must be smaller than SIGFIG");
  end

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state, state_nxt;
  logic [BEAT_W-1:0]   beat;
  logic                alive;
  logic [TRI_W-1:0]    asm_pos, load_tri, out_tri;
  logic [CW-1:0]       asm_color, load_color, out_color;
  logic                out_valid, err_q;
  logic [CNT_W-1:0]    count;
  logic                in_xfer, out_xfer, is_final_beat, frame_err, complete, load_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // A completed polygon goes straight out when the output slot is free or
  // draining this cycle; otherwise it parks in the assembly buffer (HOLD).
  always_comb begin
    vert_ready_o  = alive && (state == ACCUM);
    in_xfer       = vert_valid_i && vert_ready_o;
    out_xfer      = out_valid && !tri_halt_i;
    is_final_beat = (beat == BEAT_W'(VERTS - 1));
    frame_err     = in_xfer && (vert_last_i != is_final_beat);
    complete      = in_xfer && vert_last_i && is_final_beat;
    state_nxt     = state;
    load_out      = 1'b0;
    case (state)
      ACCUM: begin
        if (complete) begin
          if (!out_valid || out_xfer) load_out  = 1'b1;
          else                        state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_xfer) begin
          load_out  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
    load_tri = asm_pos;
    if (state == ACCUM) load_tri[(VERTS-1)*VW +: VW] = vert_pos_i;
    load_color = (state == ACCUM && beat == '0) ? vert_color_i : asm_color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive     <= 1'b0;
      beat      <= '0;
      asm_pos   <= '0;
      asm_color <= '0;
      out_tri   <= '0;
      out_color <= '0;
      out_valid <= 1'b0;
      err_q     <= 1'b0;
      count     <= '0;
    end else begin
      alive <= 1'b1;
      err_q <= frame_err;
      if (in_xfer) begin
        if (frame_err || complete) beat <= '0;
        else                       beat <= beat + 1'b1;
        for (int k = 0; k < VERTS; k++) begin
          if (beat == BEAT_W'(k)) asm_pos[k*VW +: VW] <= vert_pos_i;
        end
        if (beat == '0) asm_color <= vert_color_i;
      end
      if (load_out) begin
        out_tri   <= load_tri;
        out_color <= load_color;
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer) count <= count + 1'b1;
    end
  end

  assign tri_valid_o = out_valid;
  assign tri_o       = out_tri;
  assign color_o     = out_color;
  assign err_o       = err_q;
  assign tri_count_o = count;

endmodule

// File: tb/tb_tri_vertex_packer.sv
// Self-checking bench for tri_vertex_packer: directed scenarios plus random
// traffic, compared every cycle against a slot-level polygon model.
module tb_tri_vertex_packer;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int CNT_W  = 16;
  localparam int VW     = AXIS * SIGFIG;
  localparam int TRI_W  = VERTS * VW;
  localparam int CW     = COLORS * SIGFIG;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vert_valid_i = 1'b0, vert_last_i = 1'b0, tri_halt_i = 1'b0;
  logic [VW-1:0] vert_pos_i = '0;
  logic [CW-1:0] vert_color_i = '0;
  logic vert_ready_o, tri_valid_o, err_o;
  logic [TRI_W-1:0] tri_o;
  logic [CW-1:0] color_o;
  logic [CNT_W-1:0] tri_count_o;

  int checks = 0;
  int errors = 0;

  tri_vertex_packer #(.SIGFIG(SIGFIG), .RADIX(10), .VERTS(VERTS), .AXIS(AXIS),
                      .COLORS(COLORS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .vert_valid_i(vert_valid_i), .vert_ready_o(vert_ready_o),
    .vert_last_i(vert_last_i), .vert_pos_i(vert_pos_i), .vert_color_i(vert_color_i),
    .tri_valid_o(tri_valid_o), .tri_halt_i(tri_halt_i), .tri_o(tri_o), .color_o(color_o),
    .err_o(err_o), .tri_count_o(tri_count_o)
  );

  always #5 clk = ~clk;

  // Model: a partial-polygon queue, one held polygon, one output polygon.
  bit               m_alive, m_out_full, m_hold_full, m_err, m_last_in_x;
  logic [TRI_W-1:0] m_out_tri, m_hold_tri;
  logic [CW-1:0]    m_out_color, m_hold_color, m_part_color;
  logic [CNT_W-1:0] m_count;
  logic [VW-1:0]    m_part[$];

  task automatic model_reset();
    m_alive = 0; m_out_full = 0; m_hold_full = 0; m_err = 0; m_last_in_x = 0;
    m_count = '0; m_part.delete();
  endtask

  task automatic model_step();
    bit in_x, out_x, fin, have_poly;
    int idx;
    logic [TRI_W-1:0] poly;
    logic [CW-1:0] pcol;
    in_x = vert_valid_i && m_alive && !m_hold_full;
    out_x = m_out_full && !tri_halt_i;
    have_poly = 0; poly = '0; pcol = '0;
    m_err = 0;
    if (in_x) begin
      idx = m_part.size();
      if (idx == 0) m_part_color = vert_color_i;
      fin = (idx == VERTS - 1);
      if (vert_last_i != fin) begin
        m_err = 1;
        m_part.delete();
      end else begin
        m_part.push_back(vert_pos_i);
        if (fin) begin
          for (int k = 0; k < VERTS; k++) poly[k*VW +: VW] = m_part[k];
          pcol = m_part_color;
          have_poly = 1;
          m_part.delete();
        end
      end
    end
    if (out_x) begin
      m_count = m_count + 1'b1;
      m_out_full = 0;
      if (m_hold_full) begin
        m_out_tri = m_hold_tri; m_out_color = m_hold_color;
        m_out_full = 1; m_hold_full = 0;
      end
    end
    if (have_poly) begin
      if (!m_out_full) begin
        m_out_tri = poly; m_out_color = pcol; m_out_full = 1;
      end else begin
        m_hold_tri = poly; m_hold_color = pcol; m_hold_full = 1;
      end
    end
    m_last_in_x = in_x;
    m_alive = 1;
  endtask

  task automatic check(input string name, input logic [TRI_W-1:0] act, input logic [TRI_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("ready", TRI_W'(vert_ready_o), TRI_W'(m_alive && !m_hold_full));
    check("valid", TRI_W'(tri_valid_o), TRI_W'(m_out_full));
    check("err", TRI_W'(err_o), TRI_W'(m_err));
    check("count", TRI_W'(tri_count_o), TRI_W'(m_count));
    if (m_out_full) begin
      check("tri", tri_o, m_out_tri);
      check("color", TRI_W'(color_o), TRI_W'(m_out_color));
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, advance model, check.
  task automatic applyStimulus(input bit v, input bit l, input logic [VW-1:0] pos,
                               input logic [CW-1:0] col, input bit h);
    vert_valid_i = v; vert_last_i = l; vert_pos_i = pos; vert_color_i = col; tri_halt_i = h;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [VW-1:0] vtx(input int x, input int y, input int z);
    return {SIGFIG'(z), SIGFIG'(y), SIGFIG'(x)};
  endfunction

  task automatic sendPoly(input int base, input logic [CW-1:0] col, input bit h);
    for (int b = 0; b < VERTS; b++)
      applyStimulus(1, b == VERTS - 1, vtx(base + 3*b, base + 3*b + 1, base + 3*b + 2),
                    (b == 0) ? col : CW'(0), h);
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, h);
  endtask

  logic [TRI_W-1:0] exp_a, exp_b;
  logic [VW-1:0]    rpos;
  logic [CW-1:0]    rcol;
  bit               rv, rl, rh;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ready", TRI_W'(vert_ready_o), '0);
    check("reset_tri", tri_o, '0);
    rst_n = 1'b1;
    checkOutput();
    idle(1, 0);
    check("ready_after_release", TRI_W'(vert_ready_o), TRI_W'(1));

    // Single polygon (1,2,3),(4,5,6),(7,8,9), color 0xA.
    sendPoly(1, CW'(24'hA), 0);
    check("single_valid", TRI_W'(tri_valid_o), TRI_W'(1));
    check("single_v0x", TRI_W'(tri_o[SIGFIG-1:0]), TRI_W'(1));
    check("single_v2z", TRI_W'(tri_o[2*VW + 2*SIGFIG +: SIGFIG]), TRI_W'(9));
    check("single_color", TRI_W'(color_o), TRI_W'(24'hA));
    idle(1, 0);
    check("single_count", TRI_W'(tri_count_o), TRI_W'(1));
    check("single_drained", TRI_W'(tri_valid_o), '0);

    // Back-to-back polygons with valid held high.
    for (int p = 0; p < 4; p++) sendPoly(20 + 9*p, CW'(p + 1), 0);
    idle(1, 0);
    check("b2b_count", TRI_W'(tri_count_o), TRI_W'(5));

    // Halt held while two polygons arrive; second parks in HOLD.
    exp_a = {vtx(106,107,108), vtx(103,104,105), vtx(100,101,102)};
    exp_b = {vtx(206,207,208), vtx(203,204,205), vtx(200,201,202)};
    sendPoly(100, CW'(24'h11), 1);
    sendPoly(200, CW'(24'h22), 1);
    idle(4, 1);
    check("halt_ready_low", TRI_W'(vert_ready_o), '0);
    check("halt_first_held", tri_o, exp_a);
    idle(1, 0);
    check("halt_second_out", tri_o, exp_b);
    check("halt_valid_cont", TRI_W'(tri_valid_o), TRI_W'(1));
    check("halt_ready_back", TRI_W'(vert_ready_o), TRI_W'(1));
    idle(1, 0);
    check("halt_count", TRI_W'(tri_count_o), TRI_W'(7));

    // Early last on beat 1.
    applyStimulus(1, 0, vtx(5,5,5), CW'(3), 0);
    applyStimulus(1, 1, vtx(6,6,6), '0, 0);
    check("early_last_err", TRI_W'(err_o), TRI_W'(1));
    idle(1, 0);
    check("early_last_err_once", TRI_W'(err_o), '0);
    check("early_last_nocount", TRI_W'(tri_count_o), TRI_W'(7));
    sendPoly(300, CW'(24'h33), 0);
    idle(1, 0);

    // Missing last on beat 2, then a good polygon.
    for (int b = 0; b < VERTS; b++) applyStimulus(1, 0, vtx(b, b, b), '0, 0);
    check("missing_last_err", TRI_W'(err_o), TRI_W'(1));
    sendPoly(400, CW'(24'h44), 0);
    check("after_err_poly", TRI_W'(tri_o[SIGFIG-1:0]), TRI_W'(400));
    idle(1, 0);
    check("after_err_count", TRI_W'(tri_count_o), TRI_W'(9));

    // Reset during beat 1 while an output is halted.
    sendPoly(500, CW'(24'h55), 1);
    applyStimulus(1, 0, vtx(9,9,9), CW'(1), 1);
    vert_valid_i = 1; vert_last_i = 0; vert_pos_i = vtx(8,8,8);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", TRI_W'(tri_valid_o), '0);
    check("rst_tri", tri_o, '0);
    check("rst_color", TRI_W'(color_o), '0);
    check("rst_count", TRI_W'(tri_count_o), '0);
    check("rst_ready", TRI_W'(vert_ready_o), '0);
    check("rst_err", TRI_W'(err_o), '0);
    @(negedge clk);
    vert_valid_i = 0;
    rst_n = 1'b1;
    checkOutput();
    idle(1, 0);
    check("rst_ready_after", TRI_W'(vert_ready_o), TRI_W'(1));
    check("rst_count_after", TRI_W'(tri_count_o), '0);

    // Random traffic; source holds a beat until it is accepted.
    rv = 0; rl = 0; rpos = '0; rcol = '0; rh = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!(rv && !m_last_in_x)) begin
        rv = ($urandom_range(0, 99) < 70);
        rpos = {$urandom(), $urandom(), $urandom()};
        rcol = {$urandom(), $urandom(), $urandom()};
        rl = (m_part.size() == VERTS - 1);
        if ($urandom_range(0, 99) < 5) rl = !rl;
      end
      rh = ($urandom_range(0, 99) < 30);
      applyStimulus(rv, rl, rpos, rcol, rh);
    end
    idle(3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
